// File: rtl/mux_pipe_n.sv
// mux_pipe_n: registered N-input word multiplexer with a valid/ready
// handshake on both sides. An output register plus one skid register let the
// block stream one result per cycle while in_ready depends on state alone.
module mux_pipe_n #(
  parameter int unsigned          WIDTH       = 32,
  parameter int unsigned          NUM_IN      = 4,
  parameter int unsigned          SEL_W       = 2,
  parameter logic [WIDTH-1:0]     DEFAULT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err,
  output logic [7:0]              err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [WIDTH-1:0]   data_q,      data_d;
  logic [SEL_W-1:0]   sel_q,       sel_d;
  logic               err_q,       err_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [SEL_W-1:0]   skid_sel_q,  skid_sel_d;
  logic               skid_err_q,  skid_err_d;
  logic [7:0]         err_cnt_q,   err_cnt_d;

  logic               in_range;
  logic [WIDTH-1:0]   mux_word;
  logic               accept;
  logic               drain;

  // Select the requested slice, falling back to DEFAULT_VAL out of range
  always_comb begin
    in_range = (32'(sel) < 32'(NUM_IN));
    mux_word = DEFAULT_VAL;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) mux_word = data_in[k*WIDTH +: WIDTH];
    end
  end

  // Handshake strobes; in_ready comes from state only
  always_comb begin
    in_ready  = (state_q != TWO);
    out_valid = (state_q != EMPTY);
    accept    = in_valid & in_ready;
    drain     = out_valid & out_ready;
  end

  // Next-state, register loads and saturating error counter
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    sel_d       = sel_q;
    err_d       = err_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    skid_err_d  = skid_err_q;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          data_d  = mux_word;
          sel_d   = sel;
          err_d   = ~in_range;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          data_d = mux_word;
          sel_d  = sel;
          err_d  = ~in_range;
        end else if (accept) begin
          skid_data_d = mux_word;
          skid_sel_d  = sel;
          skid_err_d  = ~in_range;
          state_d     = TWO;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          data_d  = skid_data_q;
          sel_d   = skid_sel_q;
          err_d   = skid_err_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (accept && !in_range && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      data_q      <= '0;
      sel_q       <= '0;
      err_q       <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      skid_err_q  <= skid_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Output drive
  always_comb begin
    data_out = data_q;
    out_sel  = sel_q;
    sel_err  = err_q;
    err_cnt  = err_cnt_q;
  end

endmodule

// File: tb/tb_mux_pipe_n.sv
// tb_mux_pipe_n: directed and randomized checks of mux_pipe_n against a
// queue-based model of a two-deep in-order result buffer.
module tb_mux_pipe_n;

  localparam int unsigned W    = 32;
  localparam int unsigned N    = 3;
  localparam int unsigned SW   = 2;
  localparam logic [W-1:0] DEF = 32'hCAFE_F00D;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  data_in;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    data_out;
  logic [SW-1:0]   out_sel;
  logic            sel_err;
  logic [7:0]      err_cnt;

  mux_pipe_n #(
    .WIDTH(W), .NUM_IN(N), .SEL_W(SW), .DEFAULT_VAL(DEF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_sel(out_sel), .sel_err(sel_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic          e;
  } res_t;

  res_t        mq[$];
  res_t        last;
  int unsigned m_err;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t expect_of(input logic [SW-1:0] s, input logic [N*W-1:0] din);
    res_t r;
    logic [N*W-1:0] tmp;
    tmp = din;
    r.s = s;
    r.e = (int'(s) >= int'(N));
    r.d = r.e ? DEF : tmp[int'(s)*W +: W];
    return r;
  endfunction

  // Reference: a FIFO of at most two results, front = what is presented
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      last  = '{d: '0, s: '0, e: 1'b0};
      m_err = 0;
    end else begin
      bit acc, drn;
      acc = in_valid && (mq.size() < 2);
      drn = (mq.size() > 0) && out_ready;
      if (drn) begin
        last = mq.pop_front();
      end
      if (acc) begin
        mq.push_back(expect_of(sel, data_in));
        if (int'(sel) >= int'(N) && m_err < 255) m_err++;
      end
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    res_t cur;
    cur = (mq.size() > 0) ? mq[0] : last;
    check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    check("in_ready",  64'(in_ready),  64'(mq.size() < 2));
    check("err_cnt",   64'(err_cnt),   64'(m_err));
    check("data_out",  64'(data_out),  64'(cur.d));
    check("out_sel",   64'(out_sel),   64'(cur.s));
    check("sel_err",   64'(sel_err),   64'(cur.e));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = '0;
    data_in   = '0;
    repeat (2) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data_out",  64'(data_out),  64'd0);
    check("rst_err_cnt",   64'(err_cnt),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    #1 reset_n = 1'b1;
    step();

    // Single accept, one-cycle latency
    in_valid = 1'b1; sel = 2'd2; out_ready = 1'b1;
    data_in[2*W +: W] = 32'hDEADBEEF;
    step();
    in_valid = 1'b0;
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_data",  64'(data_out),  64'hDEADBEEF);
    check("lat_sel",   64'(out_sel),   64'd2);
    check("lat_err",   64'(sel_err),   64'd0);
    step();

    // Fill both registers with out_ready low, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 2'd0; data_in[0 +: W] = 32'h1111_1111;
    step();
    sel = 2'd1; data_in[W +: W] = 32'h2222_2222;
    step();
    sel = 2'd2; data_in[2*W +: W] = 32'h3333_3333;
    check("two_in_ready", 64'(in_ready), 64'd0);
    check("two_hold_a",   64'(data_out), 64'h1111_1111);
    step();
    in_valid = 1'b0;
    check("two_ignore",   64'(data_out), 64'h1111_1111);
    out_ready = 1'b1;
    step();
    check("drain_b",      64'(data_out), 64'h2222_2222);
    check("drain_rdy",    64'(in_ready), 64'd1);
    step();
    check("empty_valid",  64'(out_valid), 64'd0);
    check("empty_keep",   64'(data_out),  64'h2222_2222);

    // Out-of-range select and counter saturation
    in_valid = 1'b1; sel = 2'd3;
    step();
    check("oor_data", 64'(data_out), 64'(DEF));
    check("oor_err",  64'(sel_err),  64'd1);
    check("oor_cnt",  64'(err_cnt),  64'd1);
    repeat (299) step();
    in_valid = 1'b0;
    step();
    check("sat_cnt",  64'(err_cnt),  64'd255);

    // Streaming: 16 back-to-back accepts with no bubbles
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sel     = SW'($urandom_range(0, N - 1));
      data_in = {$urandom, $urandom, $urandom};
      step();
      check("strm_valid", 64'(out_valid), 64'd1);
      check("strm_ready", 64'(in_ready),  64'd1);
    end
    in_valid = 1'b0;
    step();

    // Asynchronous reset while both registers are full
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd3;
    step();
    step();
    in_valid = 1'b0;
    check("pre_rst_rdy", 64'(in_ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_cnt",   64'(err_cnt),   64'd0);
    check("arst_data",  64'(data_out),  64'd0);
    #3 reset_n = 1'b1;
    in_valid = 1'b1; sel = 2'd1; data_in[W +: W] = 32'h5A5A_A5A5;
    step();
    in_valid = 1'b0;
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_data",  64'(data_out),  64'h5A5A_A5A5);

    // Random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      sel       = SW'($urandom);
      data_in   = {$urandom, $urandom, $urandom};
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("final_empty", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_pipe_n.md
MUX_PIPE_N -- requirements
Module: mux_pipe_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 The block SHALL have parameter NUM_IN, default 4, number of data inputs, range 2..16.
REQ-003 The block SHALL have parameter SEL_W, default 2, select width in bits, with 2**SEL_W >= NUM_IN.
REQ-004 The block SHALL have parameter DEFAULT_VAL, default 0, WIDTH-bit word output for an out-of-range select.
REQ-005 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid  input  1  upstream offers sel/data_in this cycle.
REQ-008 The block SHALL have port in_ready  output  1  block can accept this cycle.
REQ-009 The block SHALL have port sel  input  SEL_W  input index to forward.
REQ-010 The block SHALL have port data_in  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-011 The block SHALL have port out_valid  output  1  data_out/out_sel/sel_err hold a valid result.
REQ-012 The block SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-013 The block SHALL have port data_out  output  WIDTH  selected word.
REQ-014 The block SHALL have port out_sel  output  SEL_W  sel value that produced data_out.
REQ-015 The block SHALL have port sel_err  output  1  result came from an out-of-range select.
REQ-016 The block SHALL have port err_cnt  output  8  saturating count of accepted out-of-range selects.

Function
REQ-017 An accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; a drain SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-018 On accept the selected word SHALL be data_in slice sel when sel < NUM_IN, else DEFAULT_VAL with sel_err=1 for that result.
REQ-019 The block SHALL hold an output register and one skid register, controlled by a state machine with states EMPTY, ONE (output register valid) and TWO (both valid).
REQ-020 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, decoded from state only, with no combinational path from out_ready.
REQ-021 out_valid SHALL be 1 in ONE and TWO and 0 in EMPTY.
REQ-022 EMPTY: accept -> load output register, go ONE; latency from accept edge to out_valid=1 SHALL be exactly one cycle.
REQ-023 ONE: accept with drain -> load output register with the new result, stay ONE; accept without drain -> load skid register, go TWO; drain without accept -> go EMPTY; neither -> hold.
REQ-024 TWO: drain -> move skid to output register, go ONE; no drain -> hold; in_valid SHALL be ignored.
REQ-025 Results SHALL leave in accept order; none SHALL be dropped or duplicated.
REQ-026 data_out, out_sel and sel_err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 In EMPTY, data_out/out_sel/sel_err SHALL retain their last values.
REQ-028 err_cnt SHALL increment by 1 on each accept with sel >= NUM_IN, saturate at 255, and never wrap.
REQ-029 Full throughput SHALL be sustained: with out_ready held 1, one accept per cycle with no bubbles.

Reset
REQ-030 While reset_n=0, immediately and independent of clk: state=EMPTY, out_valid=0, data_out=0, out_sel=0, sel_err=0, err_cnt=0, skid register cleared.
REQ-031 Reset mid-operation SHALL discard all held results; the first accept SHALL be possible on the first rising edge with reset_n=1.

Verification
REQ-032 Reset then in_valid=1, sel=2, input2=32'hDEADBEEF, out_ready=1 -> out_valid=1 next cycle, data_out=32'hDEADBEEF, out_sel=2, sel_err=0.
REQ-033 out_ready=0, accept A (sel=0) then B (sel=1) -> state TWO, in_ready=0, data_out=A held; out_ready=1 -> A then B on consecutive cycles, in_ready returns to 1.
REQ-034 NUM_IN=3, SEL_W=2, accept sel=3 -> data_out=DEFAULT_VAL, sel_err=1, err_cnt=1; 300 such accepts -> err_cnt=255.
REQ-035 Streaming 16 accepts with out_ready=1 -> 16 results in order, out_valid continuous, no in_ready drop.
REQ-036 In TWO, assert reset_n=0 asynchronously between edges -> out_valid=0 and err_cnt=0 before the next edge; after release, the first accept yields its result one cycle later.
REQ-037 Random in_valid/out_ready with a scoreboard over 10000 cycles -> zero mismatches, no loss, no duplication.
